// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg : load/store width codes, FSM states, fault codes and decode helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_MISAL = 2'b01,
        FLT_ILL   = 2'b10,
        FLT_TMO   = 2'b11
    } fault_e;

    // Unsigned widths exist only for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3)
            F3_H, F3_HU: m = a[0];
            F3_W:        m = (a != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_interface_if.sv
// ----------------------------------------------------------------------------
// mem_interface_if : word-wide memory bus with req/ack handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_interface_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_lane.sv
// ----------------------------------------------------------------------------
// mem_lane : byte enables, store lane replication, load extraction/extension
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_lane
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted   = bus_rdata_i >> {addr_lo_i, 3'b000};
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        rdata_ext_o = w_shifted;

        // funct3[1:0] selects the width; bit 2 only selects zero-extension.
        case (funct3_i[1:0])
            2'b00: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase

        case (funct3_i)
            F3_B:    rdata_ext_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    rdata_ext_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   rdata_ext_o = {24'd0, w_shifted[7:0]};
            F3_HU:   rdata_ext_o = {16'd0, w_shifted[15:0]};
            default: rdata_ext_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_interface.sv
// ----------------------------------------------------------------------------
// mem_interface : RV32I load/store unit driving a req/ack word memory bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_interface
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               we,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fault,
    mem_interface_if.master    bus
);

    state_e      state_q, state_d;
    fault_e      fault_q, fault_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        bwe_q, bwe_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  bbe_q, bbe_d;
    logic [31:0] bwdata_q, bwdata_d;

    logic [2:0]  w_lane_f3;
    logic [1:0]  w_lane_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [31:0] w_rext;

    // Lanes decode the live request in IDLE and the latched one afterwards.
    assign w_lane_f3 = (state_q == ST_IDLE) ? funct3    : funct3_q;
    assign w_lane_lo = (state_q == ST_IDLE) ? addr[1:0] : addr_lo_q;

    mem_lane u_lane (
        .funct3_i    (w_lane_f3),
        .addr_lo_i   (w_lane_lo),
        .wdata_i     (wdata),
        .bus_rdata_i (bus.bus_rdata),
        .be_o        (w_be),
        .wdata_rep_o (w_wrep),
        .rdata_ext_o (w_rext)
    );

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        addr_lo_d = addr_lo_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        bwe_d     = bwe_q;
        baddr_d   = baddr_q;
        bbe_d     = bbe_q;
        bwdata_d  = bwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_lo_d = addr[1:0];
                    funct3_d  = funct3;
                    we_d      = we;
                    fault_d   = FLT_NONE;
                    cnt_d     = 32'd0;
                    if (!f3_legal(we, funct3)) begin
                        fault_d = FLT_ILL;
                        state_d = ST_FINISH;
                    end else if (f3_misaligned(funct3, addr[1:0])) begin
                        fault_d = FLT_MISAL;
                        state_d = ST_FINISH;
                    end else begin
                        state_d  = ST_ACCESS;
                        req_d    = 1'b1;
                        bwe_d    = we;
                        baddr_d  = {addr[31:2], 2'b00};
                        bbe_d    = w_be;
                        bwdata_d = w_wrep;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.bus_ack || (TIMEOUT != 0 && (cnt_q + 32'd1) == TIMEOUT)) begin
                    state_d  = ST_FINISH;
                    cnt_d    = 32'd0;
                    req_d    = 1'b0;
                    bwe_d    = 1'b0;
                    baddr_d  = 32'd0;
                    bbe_d    = 4'd0;
                    bwdata_d = 32'd0;
                    if (bus.bus_ack) begin
                        if (!we_q) rdata_d = w_rext;
                    end else begin
                        fault_d = FLT_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fault_q   <= FLT_NONE;
            addr_lo_q <= 2'd0;
            funct3_q  <= 3'd0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 32'd0;
            cnt_q     <= 32'd0;
            req_q     <= 1'b0;
            bwe_q     <= 1'b0;
            baddr_q   <= 32'd0;
            bbe_q     <= 4'd0;
            bwdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            addr_lo_q <= addr_lo_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            bwe_q     <= bwe_d;
            baddr_q   <= baddr_d;
            bbe_q     <= bbe_d;
            bwdata_q  <= bwdata_d;
        end
    end

    assign rdata         = rdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign fault         = fault_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = bwe_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_be    = bbe_q;
    assign bus.bus_wdata = bwdata_q;

endmodule

`default_nettype wire
